// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned JT_W  = 26;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } seq_state_e;

  // Branch target: word offset relative to the branch's own PC+4, modulo 2^32.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pcp4,
                                                     input logic [PC_W-1:0] imm_sext);
    return pcp4 + (imm_sext << 2);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/hazard inputs and fetch-side outputs of the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  import pc_sequencer_pkg::*;

  logic              stall;
  logic              branch_ex;
  logic              bne_ex;
  logic              zero_ex;
  logic [PC_W-1:0]   pcp4_ex;
  logic [IMM_W-1:0]  imm_ex;
  logic              jump_id;
  logic [JT_W-1:0]   jtarget_id;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus4;
  logic              imem_req;
  logic              flush_ifid;
  logic              flush_idex;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output stall, branch_ex, bne_ex, zero_ex, pcp4_ex, imm_ex, jump_id, jtarget_id,
    input  pc, pc_plus4, imem_req, flush_ifid, flush_idex, redirect_cnt
  );

  modport slave (
    input  stall, branch_ex, bne_ex, zero_ex, pcp4_ex, imm_ex, jump_id, jtarget_id,
    output pc, pc_plus4, imem_req, flush_ifid, flush_idex, redirect_cnt
  );

endinterface

// File: rtl/pc_sequencer_sign_extend.sv
// Sign extension of an immediate field to a wider datapath word.
module sign_extend #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  val_i,
  output logic [OUT_W-1:0] val_o
);

  assign val_o = {{(OUT_W-IN_W){val_i[IN_W-1]}}, val_i};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential fetch, ID jumps, EX branches (predict not-taken),
// pipeline flush generation and a saturating redirect counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned  CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_sequencer_if.slave    bus
);

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   imm_sext;
  logic [PC_W-1:0]   br_target;
  logic [PC_W-1:0]   j_target;
  logic              imem_req_q;
  logic              br_taken;
  logic              flush_ifid;
  logic              flush_idex;
  logic              redirect;
  logic [CNT_W-1:0]  cnt_q;

  sign_extend #(
    .IN_W  (IMM_W),
    .OUT_W (PC_W)
  ) u_sext (
    .val_i (bus.imm_ex),
    .val_o (imm_sext)
  );

  assign pc_plus4  = pc_q + PC_INC;
  assign br_target = branch_target(bus.pcp4_ex, imm_sext);
  assign j_target  = {pc_plus4[31:28], bus.jtarget_id, 2'b00};

  // Next-PC selection and state transition; an EX branch outranks a stall since it is older.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_taken   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    redirect   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        br_taken = (bus.branch_ex & bus.zero_ex) | (bus.bne_ex & ~bus.zero_ex);
        if (br_taken) begin
          pc_d       = br_target;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          redirect   = 1'b1;
          state_d    = REDIRECT;
        end else if (bus.jump_id && !bus.stall) begin
          pc_d       = j_target;
          flush_ifid = 1'b1;
          redirect   = 1'b1;
        end else if (!bus.stall) begin
          pc_d = pc_plus4;
        end
      end
      REDIRECT: begin
        // ID and EX hold flushed bubbles here, so their control inputs are ignored.
        state_d = RUN;
        if (!bus.stall) pc_d = pc_plus4;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= (state_d != BOOT);
    end
  end

  // Saturating count of taken redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.imem_req     = imem_req_q;
  assign bus.flush_ifid   = flush_ifid;
  assign bus.flush_idex   = flush_idex;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed cycle-by-cycle vectors for pc_sequencer plus reset and saturation sequences.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int unsigned TB_CNT_W = 8;
  localparam int unsigned NVEC     = 23;

  typedef struct {
    logic        stall;
    logic        br;
    logic        bne;
    logic        zero;
    logic [31:0] pcp4;
    logic [15:0] imm;
    logic        jump;
    logic [25:0] jt;
    logic [31:0] exp_pc;
    logic        exp_fi;
    logic        exp_fe;
    logic        exp_req;
    logic [7:0]  exp_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs [NVEC];

  pc_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic br, input logic bn, input logic z,
                              input logic [31:0] p4, input logic [15:0] im,
                              input logic j, input logic [25:0] jt,
                              input logic [31:0] epc, input logic efi, input logic efe,
                              input logic ereq, input logic [7:0] ecnt);
    vec_t v;
    v.stall = st; v.br = br; v.bne = bn; v.zero = z; v.pcp4 = p4; v.imm = im;
    v.jump = j; v.jt = jt; v.exp_pc = epc; v.exp_fi = efi; v.exp_fe = efe;
    v.exp_req = ereq; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic drive(input logic st, input logic br, input logic bn, input logic z,
                       input logic [31:0] p4, input logic [15:0] im,
                       input logic j, input logic [25:0] jt);
    bus.stall = st; bus.branch_ex = br; bus.bne_ex = bn; bus.zero_ex = z;
    bus.pcp4_ex = p4; bus.imm_ex = im; bus.jump_id = j; bus.jtarget_id = jt;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            st br bn z  pcp4          imm       j  jt        exp_pc        fi fe rq cnt
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_0000, 0, 0, 0, 8'd0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_0000, 0, 0, 1, 8'd0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_0004, 0, 0, 1, 8'd0);
    vecs[3]  = mk(0, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_0008, 0, 0, 1, 8'd0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,        16'h0,    1, 26'h10,   32'h0000_000C, 1, 0, 1, 8'd0);
    vecs[5]  = mk(0, 1, 0, 1, 32'h3C,       16'h0004, 0, 26'h0,    32'h0000_0040, 1, 1, 1, 8'd1);
    vecs[6]  = mk(0, 1, 0, 1, 32'h3C,       16'h0004, 1, 26'h10,   32'h0000_004C, 0, 0, 1, 8'd2);
    vecs[7]  = mk(0, 0, 1, 0, 32'h4,        16'hFFFE, 0, 26'h0,    32'h0000_0050, 1, 1, 1, 8'd2);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'hFFFF_FFFC, 0, 0, 1, 8'd3);
    vecs[9]  = mk(1, 1, 0, 1, 32'h100,      16'h0010, 0, 26'h0,    32'h0000_0000, 1, 1, 1, 8'd3);
    vecs[10] = mk(1, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_0140, 0, 0, 1, 8'd4);
    vecs[11] = mk(1, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_0140, 0, 0, 1, 8'd4);
    vecs[12] = mk(1, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_0140, 0, 0, 1, 8'd4);
    vecs[13] = mk(1, 0, 0, 0, 32'h0,        16'h0,    1, 26'h40,   32'h0000_0140, 0, 0, 1, 8'd4);
    vecs[14] = mk(0, 0, 0, 0, 32'h0,        16'h0,    1, 26'h40,   32'h0000_0140, 1, 0, 1, 8'd4);
    vecs[15] = mk(0, 1, 0, 1, 32'h1000_0000, 16'h0003, 0, 26'h0,   32'h0000_0100, 1, 1, 1, 8'd5);
    vecs[16] = mk(0, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h1000_000C, 0, 0, 1, 8'd6);
    vecs[17] = mk(0, 0, 0, 0, 32'h0,        16'h0,    1, 26'h40,   32'h1000_0010, 1, 0, 1, 8'd6);
    vecs[18] = mk(0, 1, 0, 1, 32'h2000,     16'h0008, 1, 26'h40,   32'h1000_0100, 1, 1, 1, 8'd7);
    vecs[19] = mk(0, 0, 0, 0, 32'h0,        16'h0,    0, 26'h0,    32'h0000_2020, 0, 0, 1, 8'd8);
    vecs[20] = mk(0, 1, 0, 0, 32'h3000,     16'h0004, 0, 26'h0,    32'h0000_2024, 0, 0, 1, 8'd8);
    vecs[21] = mk(0, 0, 1, 1, 32'h3000,     16'h0004, 0, 26'h0,    32'h0000_2028, 0, 0, 1, 8'd8);
    vecs[22] = mk(0, 1, 0, 1, 32'h2030,     16'h0000, 0, 26'h0,    32'h0000_202C, 1, 1, 1, 8'd8);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0);
    #1;
    check("reset_pc", bus.pc, 32'h0);
    check("reset_req", 32'(bus.imem_req), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].bne, vecs[i].zero,
            vecs[i].pcp4, vecs[i].imm, vecs[i].jump, vecs[i].jt);
      #1;
      check($sformatf("v%0d_pc", i), bus.pc, vecs[i].exp_pc);
      check($sformatf("v%0d_pc_plus4", i), bus.pc_plus4, vecs[i].exp_pc + 32'd4);
      check($sformatf("v%0d_flush_ifid", i), 32'(bus.flush_ifid), 32'(vecs[i].exp_fi));
      check($sformatf("v%0d_flush_idex", i), 32'(bus.flush_idex), 32'(vecs[i].exp_fe));
      check($sformatf("v%0d_imem_req", i), 32'(bus.imem_req), 32'(vecs[i].exp_req));
      check($sformatf("v%0d_cnt", i), 32'(bus.redirect_cnt), 32'(vecs[i].exp_cnt));
      @(posedge clk);
      #2;
    end

    // In REDIRECT with a taken beq still presented; then async reset between edges.
    drive(0, 1, 0, 1, 32'h5000, 16'h0004, 1, 26'h10);
    #1;
    check("redir_pc", bus.pc, 32'h0000_2030);
    check("redir_cnt", 32'(bus.redirect_cnt), 32'd9);
    check("redir_state", 32'(dut.state_q), 32'(REDIRECT));
    check("redir_mask_fi", 32'(bus.flush_ifid), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("async_pc", bus.pc, 32'h0);
    check("async_cnt", 32'(bus.redirect_cnt), 32'h0);
    check("async_state", 32'(dut.state_q), 32'(BOOT));
    check("async_req", 32'(bus.imem_req), 32'h0);
    check("async_fi", 32'(bus.flush_ifid), 32'h0);
    @(posedge clk);
    #2;
    check("held_pc", bus.pc, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 16'h0, 0, 26'h0);
    rst_n = 1'b1;
    #1;
    check("boot_req", 32'(bus.imem_req), 32'h0);
    @(posedge clk);
    #2;
    check("boot_run_req", 32'(bus.imem_req), 32'h1);
    check("boot_pc0", bus.pc, 32'h0);
    @(posedge clk);
    #2;
    check("boot_pc4", bus.pc, 32'h4);
    @(posedge clk);
    #2;
    check("boot_pc8", bus.pc, 32'h8);

    // Back-to-back jumps to 0 drive the counter past its saturation point.
    drive(0, 0, 0, 0, 32'h0, 16'h0, 1, 26'h0);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #2;
      if (k == 253) check("sat_cnt_254", 32'(bus.redirect_cnt), 32'd254);
    end
    check("sat_cnt", 32'(bus.redirect_cnt), 32'hFF);
    check("sat_pc", bus.pc, 32'h0);
    check("sat_fi", 32'(bus.flush_ifid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
